// File: rtl/tournament_predictor.sv
// Tournament branch predictor: bimodal and gshare tables arbitrated by a per-PC chooser,
// with a speculative global history register repaired on misprediction.
module tournament_predictor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned GHIST_BITS = 8,
  parameter int unsigned IDX_BITS   = 8,
  parameter int unsigned CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_stall,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_pred,
  output logic                  o_pred_gshare,
  output logic                  o_pred_2bit,
  output logic [GHIST_BITS-1:0] o_ghistory,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [GHIST_BITS-1:0] i_fb_ghistory,
  input  logic                  i_fb_pred,
  input  logic                  i_fb_pred_gshare,
  input  logic                  i_fb_pred_2bit,
  input  logic                  i_fb_outcome,
  output logic                  o_recover,
  output logic [31:0]           o_branch_cnt,
  output logic [31:0]           o_mispred_cnt
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CtrZero = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CtrOne  = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CtrInit = {1'b0, {(CTR_BITS-1){1'b1}}};

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                   input logic up);
    if (up) return (c == CtrMax) ? c : c + CtrOne;
    else    return (c == CtrZero) ? c : c - CtrOne;
  endfunction

  logic [CTR_BITS-1:0] bim_q [Entries];
  logic [CTR_BITS-1:0] gsh_q [Entries];
  logic [CTR_BITS-1:0] chs_q [Entries];

  logic [GHIST_BITS-1:0] ghr_q, ghr_d;
  logic                  recover_q;
  logic [31:0]           branch_cnt_q, mispred_cnt_q;

  logic [IDX_BITS-1:0] req_idx, req_hist, req_gsh_idx;
  logic [IDX_BITS-1:0] fb_idx, fb_hist, fb_gsh_idx;
  logic [CTR_BITS-1:0] bim_rd, gsh_rd, chs_rd;
  logic                mispredict;

  assign req_idx = i_req_pc[IDX_BITS+1:2];
  assign fb_idx  = i_fb_pc[IDX_BITS+1:2];

  // History is truncated (LSBs kept) or zero-extended to the index width.
  if (GHIST_BITS >= IDX_BITS) begin : g_hist_trunc
    assign req_hist = ghr_q[IDX_BITS-1:0];
    assign fb_hist  = i_fb_ghistory[IDX_BITS-1:0];
  end else begin : g_hist_ext
    assign req_hist = {{(IDX_BITS-GHIST_BITS){1'b0}}, ghr_q};
    assign fb_hist  = {{(IDX_BITS-GHIST_BITS){1'b0}}, i_fb_ghistory};
  end

  assign req_gsh_idx = req_idx ^ req_hist;
  assign fb_gsh_idx  = fb_idx ^ fb_hist;

  // Reads come straight from the registers, so a same-cycle update is seen next cycle.
  assign bim_rd        = bim_q[req_idx];
  assign gsh_rd        = gsh_q[req_gsh_idx];
  assign chs_rd        = chs_q[req_idx];
  assign o_pred_2bit   = bim_rd[CTR_BITS-1];
  assign o_pred_gshare = gsh_rd[CTR_BITS-1];
  assign o_pred        = chs_rd[CTR_BITS-1] ? o_pred_gshare : o_pred_2bit;
  assign o_ghistory    = ghr_q;

  assign mispredict = i_fb_valid && (i_fb_pred != i_fb_outcome);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        bim_q[i] <= CtrInit;
        gsh_q[i] <= CtrInit;
        chs_q[i] <= CtrInit;
      end
    end else if (i_fb_valid) begin
      bim_q[fb_idx]     <= sat_step(bim_q[fb_idx], i_fb_outcome);
      gsh_q[fb_gsh_idx] <= sat_step(gsh_q[fb_gsh_idx], i_fb_outcome);
      if (i_fb_pred_gshare != i_fb_pred_2bit) begin
        chs_q[fb_idx] <= sat_step(chs_q[fb_idx], i_fb_pred_gshare == i_fb_outcome);
      end
    end
  end

  // Recovery takes priority over the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict) begin
      ghr_d = {i_fb_ghistory[GHIST_BITS-2:0], i_fb_outcome};
    end else if (i_req_valid && !i_req_stall) begin
      ghr_d = {ghr_q[GHIST_BITS-2:0], o_pred};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q         <= '0;
      recover_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      recover_q <= mispredict;
      if (i_fb_valid && (branch_cnt_q != 32'hFFFF_FFFF)) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign o_recover     = recover_q;
  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{i_req_pc[ADDR_WIDTH-1:IDX_BITS+2], i_req_pc[1:0],
                         i_fb_pc[ADDR_WIDTH-1:IDX_BITS+2], i_fb_pc[1:0],
                         i_fb_ghistory[GHIST_BITS-1]};

endmodule

// File: tb/tb_tournament_predictor.sv
// Directed bench for tournament_predictor with hand-computed expectations.
module tb_tournament_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req_valid, i_req_stall;
  logic [31:0] i_req_pc;
  logic        o_pred, o_pred_gshare, o_pred_2bit;
  logic [7:0]  o_ghistory;
  logic        i_fb_valid;
  logic [31:0] i_fb_pc;
  logic [7:0]  i_fb_ghistory;
  logic        i_fb_pred, i_fb_pred_gshare, i_fb_pred_2bit, i_fb_outcome;
  logic        o_recover;
  logic [31:0] o_branch_cnt, o_mispred_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tournament_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .i_req_stall      (i_req_stall),
    .i_req_pc         (i_req_pc),
    .o_pred           (o_pred),
    .o_pred_gshare    (o_pred_gshare),
    .o_pred_2bit      (o_pred_2bit),
    .o_ghistory       (o_ghistory),
    .i_fb_valid       (i_fb_valid),
    .i_fb_pc          (i_fb_pc),
    .i_fb_ghistory    (i_fb_ghistory),
    .i_fb_pred        (i_fb_pred),
    .i_fb_pred_gshare (i_fb_pred_gshare),
    .i_fb_pred_2bit   (i_fb_pred_2bit),
    .i_fb_outcome     (i_fb_outcome),
    .o_recover        (o_recover),
    .o_branch_cnt     (o_branch_cnt),
    .o_mispred_cnt    (o_mispred_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid      = 1'b0;
    i_req_stall      = 1'b0;
    i_req_pc         = '0;
    i_fb_valid       = 1'b0;
    i_fb_pc          = '0;
    i_fb_ghistory    = '0;
    i_fb_pred        = 1'b0;
    i_fb_pred_gshare = 1'b0;
    i_fb_pred_2bit   = 1'b0;
    i_fb_outcome     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #1 rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_fb(input logic [31:0] pc, input logic [7:0] gh, input logic pred,
                        input logic pg, input logic p2, input logic outcome);
    i_fb_valid       = 1'b1;
    i_fb_pc          = pc;
    i_fb_ghistory    = gh;
    i_fb_pred        = pred;
    i_fb_pred_gshare = pg;
    i_fb_pred_2bit   = p2;
    i_fb_outcome     = outcome;
  endtask

  task automatic send_fb(input logic [31:0] pc, input logic [7:0] gh, input logic pred,
                         input logic pg, input logic p2, input logic outcome);
    set_fb(pc, gh, pred, pg, p2, outcome);
    step();
    i_fb_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_gh [3];
    exp_gh = '{8'h01, 8'h03, 8'h07};

    // Reset state, observed before any clock edge.
    clear_inputs();
    i_req_valid = 1'b1;
    i_req_pc    = 32'h1234;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_pred", {31'd0, o_pred}, 32'd0);
    check_eq("rst_gshare", {31'd0, o_pred_gshare}, 32'd0);
    check_eq("rst_2bit", {31'd0, o_pred_2bit}, 32'd0);
    check_eq("rst_ghist", {24'd0, o_ghistory}, 32'h00);
    check_eq("rst_bcnt", o_branch_cnt, 32'd0);
    check_eq("rst_mcnt", o_mispred_cnt, 32'd0);
    check_eq("rst_recover", {31'd0, o_recover}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i_req_valid = 1'b0;

    // Bimodal training at 0x40 (idx 0x10); same-cycle read sees the old value.
    i_req_pc = 32'h40;
    set_fb(32'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("rdw_pre", {31'd0, o_pred_2bit}, 32'd0);
    step();
    check_eq("rdw_post", {31'd0, o_pred_2bit}, 32'd1);
    step();
    i_fb_valid = 1'b0;
    // Both feedbacks mispredicted (pred 0, outcome 1): GHR = {0..,1}.
    check_eq("bim_bcnt", o_branch_cnt, 32'd2);
    check_eq("bim_mcnt", o_mispred_cnt, 32'd2);
    check_eq("bim_recover", {31'd0, o_recover}, 32'd1);
    check_eq("bim_ghist", {24'd0, o_ghistory}, 32'h01);
    check_eq("bim_2bit", {31'd0, o_pred_2bit}, 32'd1);
    check_eq("bim_pred", {31'd0, o_pred}, 32'd1);
    check_eq("bim_gshare_idx11", {31'd0, o_pred_gshare}, 32'd0);
    step();
    check_eq("recover_drop", {31'd0, o_recover}, 32'd0);

    // GHR shift and stall.
    do_reset();
    i_req_pc    = 32'h200;
    i_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("shift0_pred", {31'd0, o_pred}, 32'd0);
      step();
      check_eq("shift0_ghist", {24'd0, o_ghistory}, 32'h00);
    end
    i_req_stall = 1'b1;
    step();
    check_eq("stall0_ghist", {24'd0, o_ghistory}, 32'h00);
    i_req_valid = 1'b0;
    i_req_stall = 1'b0;
    send_fb(32'h100, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    send_fb(32'h100, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("train_mcnt", o_mispred_cnt, 32'd0);
    i_req_pc    = 32'h100;
    i_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("shift1_pred", {31'd0, o_pred}, 32'd1);
      step();
      check_eq("shift1_ghist", {24'd0, o_ghistory}, {24'd0, exp_gh[i]});
    end
    i_req_stall = 1'b1;
    #1;
    check_eq("stall1_pred", {31'd0, o_pred}, 32'd1);
    step();
    check_eq("stall1_ghist", {24'd0, o_ghistory}, 32'h07);
    i_req_valid = 1'b0;
    i_req_stall = 1'b0;

    // Recovery collision. GHR is set to 0xAA by one recovery (0x55 << 1 | 0),
    // so the mispredict count ends at 2.
    do_reset();
    send_fb(32'h0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("coll_setup_ghist", {24'd0, o_ghistory}, 32'hAA);
    i_req_valid = 1'b1;
    i_req_pc    = 32'h300;
    set_fb(32'h400, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    clear_inputs();
    check_eq("coll_ghist", {24'd0, o_ghistory}, 32'h79);
    check_eq("coll_recover", {31'd0, o_recover}, 32'd1);
    check_eq("coll_mcnt", o_mispred_cnt, 32'd2);
    check_eq("coll_bcnt", o_branch_cnt, 32'd2);

    // Saturation at 0x40: ten taken, one more taken, then not-taken steps down.
    do_reset();
    i_req_pc = 32'h40;
    for (int i = 0; i < 10; i++) send_fb(32'h40, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("sat10_2bit", {31'd0, o_pred_2bit}, 32'd1);
    check_eq("sat10_gshare", {31'd0, o_pred_gshare}, 32'd1);
    send_fb(32'h40, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("sat11_2bit", {31'd0, o_pred_2bit}, 32'd1);
    send_fb(32'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_nt1_2bit", {31'd0, o_pred_2bit}, 32'd1);
    check_eq("sat_nt1_pred", {31'd0, o_pred}, 32'd1);
    send_fb(32'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_nt2_2bit", {31'd0, o_pred_2bit}, 32'd0);
    check_eq("sat_bcnt", o_branch_cnt, 32'd13);
    check_eq("sat_mcnt", o_mispred_cnt, 32'd0);

    // Chooser at 0x80 (idx 0x20): first fb mispredicts so GHR = 0x01 and the
    // gshare read lands on untrained idx 0x21 (0) while bimodal reads 1.
    do_reset();
    send_fb(32'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    send_fb(32'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    i_req_pc = 32'h80;
    #1;
    check_eq("chs_2bit", {31'd0, o_pred_2bit}, 32'd1);
    check_eq("chs_gshare", {31'd0, o_pred_gshare}, 32'd0);
    check_eq("chs_pred", {31'd0, o_pred}, 32'd0);
    // One bimodal win steps 11 -> 10: still selects gshare.
    send_fb(32'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("chs_back_pred", {31'd0, o_pred}, 32'd0);

    // Reset mid-operation discards the in-flight feedback.
    set_fb(32'h40, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("mid_bcnt_pre", o_branch_cnt, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_bcnt", o_branch_cnt, 32'd0);
    check_eq("mid_recover", {31'd0, o_recover}, 32'd0);
    check_eq("mid_ghist", {24'd0, o_ghistory}, 32'h00);
    step();
    check_eq("mid_hold_bcnt", o_branch_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    step();
    check_eq("post_bcnt", o_branch_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tournament_predictor.md
TOURNAMENT_PREDICTOR -- requirements
Module: tournament_predictor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 32, PC width.
- GHIST_BITS, 8, global history length.
- IDX_BITS, 8, table index width; all tables have 2^IDX_BITS entries.
- CTR_BITS, 2, saturating counter width, legal range 2..4.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  reset.
- i_req_valid  in  1  fetch predicts a branch this cycle.
- i_req_stall  in  1  fetch is stalled; prediction is not consumed.
- i_req_pc  in  ADDR_WIDTH  branch PC.
- o_pred  out  1  final prediction (1=TAKEN, 0=NOT_TAKEN).
- o_pred_gshare  out  1  gshare component prediction.
- o_pred_2bit  out  1  bimodal component prediction.
- o_ghistory  out  GHIST_BITS  history used for this prediction, carried down the pipe.
- i_fb_valid  in  1  resolved branch from ALU.
- i_fb_pc  in  ADDR_WIDTH  resolved branch PC.
- i_fb_ghistory  in  GHIST_BITS  history carried with that branch.
- i_fb_pred, i_fb_pred_gshare, i_fb_pred_2bit  in  1 each  predictions carried with that branch.
- i_fb_outcome  in  1  actual outcome.
- o_recover  out  1  registered pulse: misprediction recovery applied to history last cycle.
- o_branch_cnt  out  32  resolved branch count.
- o_mispred_cnt  out  32  misprediction count.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 Indexing SHALL be: bim_idx = chs_idx = i_req_pc[IDX_BITS+1:2]; gsh_idx = bim_idx XOR history, with history zero-extended or truncated (LSBs kept) to IDX_BITS. Feedback uses i_fb_pc and i_fb_ghistory the same way.
REQ-005 Prediction SHALL be combinational, with zero latency.
- o_pred_2bit = MSB of the BIM entry; o_pred_gshare = MSB of the GSH entry.
- o_pred = o_pred_gshare when the CHS entry MSB is 1, otherwise o_pred_2bit.
- o_ghistory = current speculative GHR.
REQ-006 Read-during-write: a prediction in the same cycle as a feedback update to the same entry SHALL return the pre-update value; the update is visible next cycle.
REQ-007 Speculative GHR update: on i_req_valid && !i_req_stall, GHR <= {GHR[GHIST_BITS-2:0], o_pred}.
REQ-008 Feedback on i_fb_valid (all updates saturating, no wrap):
- BIM[fb] and GSH[fb] move +1 on taken, -1 on not taken.
- CHS[fb] updates only when i_fb_pred_gshare != i_fb_pred_2bit: +1 if gshare matched the outcome, -1 if bimodal matched.
REQ-009 A misprediction is i_fb_valid && i_fb_pred != i_fb_outcome. On a misprediction:
- GHR <= {i_fb_ghistory[GHIST_BITS-2:0], i_fb_outcome}.
- o_recover = 1 next cycle, otherwise 0.
REQ-010 If a misprediction and a REQ-007 shift occur in the same cycle, recovery SHALL win and the shift is discarded.
REQ-011 Counters, on i_fb_valid:
- o_branch_cnt += 1.
- o_mispred_cnt += 1 on a misprediction.
- Both saturate at 32'hFFFF_FFFF.
REQ-012 Predictions from stalled requests SHALL still be driven and SHALL NOT alter state.

Reset
REQ-013 While rst_n = 0, immediately and independent of clk:
- GHR = 0.
- Every BIM and GSH entry = 2^(CTR_BITS-1)-1 (weakly not taken).
- Every CHS entry = 2^(CTR_BITS-1)-1 (weakly bimodal).
- o_recover = 0; both counters = 0.
- Combinational outputs reflect these values.
REQ-014 Reset asserted mid-operation SHALL discard any in-flight update in that cycle.
REQ-015 The first edge after deassertion SHALL behave as normal operation.

Verification
REQ-016 Reset with defaults: any PC SHALL give o_pred = 0, o_pred_gshare = 0, o_pred_2bit = 0, o_ghistory = 8'h00, both counters 0.
REQ-017 Bimodal training: fb pc = 0x40, outcome 1, twice with ghistory 0. Next request at pc 0x40 SHALL give o_pred_2bit = 1; o_pred = 1 (chooser unchanged, since both components agreed).
REQ-018 GHR shift and stall: three unstalled requests predicting 0,0,0, then one stalled request. o_ghistory SHALL read 8'h00 throughout. With BIM trained taken at that PC, GHR SHALL become 8'h01, 8'h03, 8'h07 and hold during the stall.
REQ-019 Recovery collision: GHR = 8'hAA; same cycle, unstalled request plus fb mispredict with ghistory 8'h3C, outcome 1. Next cycle GHR SHALL be 8'h79, o_recover = 1, o_mispred_cnt = 1.
REQ-020 Saturation: ten taken feedbacks to one entry with CTR_BITS = 2. Entry SHALL read 2'b11 and stay there; one not-taken feedback then gives 2'b10 and prediction still 1.
REQ-021 Chooser: fb with pred_gshare = 1, pred_2bit = 0, outcome 1, twice at pc 0x80. CHS[0x20] SHALL reach 2'b11, and o_pred at pc 0x80 SHALL follow o_pred_gshare.
